// File: rtl/sb_trig_holdoff.sv
// sb_trig_holdoff: turns a one-cycle trigger into an acknowledged request with holdoff dead-time
// and keeps saturating accept/miss counters.
module sb_trig_holdoff (
    input  logic        CLK120,
    input  logic        RESET,
    input  logic        TRIG_IN,
    input  logic        ENABLE,
    input  logic [11:0] HOLDOFF,
    input  logic        TRIG_ACK,
    input  logic        COUNT_CLEAR,
    output logic        TRIG_OUT,
    output logic        TRIG_PENDING,
    output logic        BUSY,
    output logic [15:0] ACCEPT_COUNT,
    output logic [15:0] MISS_COUNT
);
    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_HOLDOFF} state_t;
    state_t      state, state_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic        accept, miss;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept    = TRIG_IN && ENABLE;
                state_nxt = accept ? ST_PENDING : ST_IDLE;
            end
            ST_PENDING: if (TRIG_ACK) begin
                cnt_nxt   = HOLDOFF;
                state_nxt = (HOLDOFF != 12'd0) ? ST_HOLDOFF : ST_IDLE;
            end
            ST_HOLDOFF: begin
                cnt_nxt   = cnt - 12'd1;
                state_nxt = (cnt == 12'd1) ? ST_IDLE : ST_HOLDOFF;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
    assign miss         = TRIG_IN && (state != ST_IDLE);
    assign TRIG_PENDING = (state == ST_PENDING);
    assign BUSY         = (state != ST_IDLE);
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            cnt          <= 12'd0;
            TRIG_OUT     <= 1'b0;
            ACCEPT_COUNT <= 16'd0;
            MISS_COUNT   <= 16'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            TRIG_OUT <= accept;
            // clear wins over a same-cycle increment
            if (COUNT_CLEAR) begin
                ACCEPT_COUNT <= 16'd0;
                MISS_COUNT   <= 16'd0;
            end else begin
                if (accept && ACCEPT_COUNT != 16'hFFFF) ACCEPT_COUNT <= ACCEPT_COUNT + 16'd1;
                if (miss && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
endmodule

// File: doc/sb_trig_holdoff.md
SB_TRIG_HOLDOFF -- requirements
Module: sb_trig_holdoff

Downstream stage of the single-bin trigger. It converts the trigger's one-cycle TRIG pulse into an acknowledged trigger request with programmable dead-time (holdoff), and keeps accepted and missed trigger counts.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; there are no parameters.
REQ-002 CLK120  input  1  120 MHz system clock; all logic SHALL be rising-edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 TRIG_IN  input  1  one-cycle trigger pulse from the single-bin trigger stage.
REQ-005 ENABLE  input  1  1 = triggers may be accepted.
REQ-006 HOLDOFF  input  12  dead-time in CLK120 cycles after acknowledge; 0 = none.
REQ-007 TRIG_ACK  input  1  DAQ acknowledge of a pending trigger.
REQ-008 COUNT_CLEAR  input  1  synchronous clear of both counters.
REQ-009 TRIG_OUT  output  1  registered one-cycle pulse per accepted trigger.
REQ-010 TRIG_PENDING  output  1  high while an accepted trigger awaits TRIG_ACK.
REQ-011 BUSY  output  1  high whenever state is not IDLE.
REQ-012 ACCEPT_COUNT  output  16  number of accepted triggers, saturating.
REQ-013 MISS_COUNT  output  16  number of TRIG_IN pulses arriving while BUSY, saturating.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, PENDING and HOLDOFF.
REQ-015 In IDLE, TRIG_IN=1 with ENABLE=1 at cycle n SHALL produce:
  - TRIG_OUT=1 for cycle n+1 only;
  - state PENDING from n+1;
  - ACCEPT_COUNT incremented at n+1.
REQ-016 In IDLE, TRIG_IN with ENABLE=0 SHALL be ignored: no output pulse and no count change.
REQ-017 PENDING SHALL persist until TRIG_ACK=1, irrespective of ENABLE.
  - TRIG_PENDING = 1 exactly while state = PENDING.
REQ-018 In PENDING, TRIG_ACK=1 at cycle m SHALL:
  - sample HOLDOFF into a 12-bit down-counter;
  - enter HOLDOFF at m+1 if HOLDOFF != 0, otherwise IDLE at m+1.
REQ-019 In HOLDOFF, the counter SHALL decrement once per cycle.
  - Transition to IDLE when the counter equals 1.
  - BUSY is therefore high in cycles m+1 .. m+HOLDOFF, and a new TRIG_IN is acceptable from cycle m+HOLDOFF+1.
REQ-020 HOLDOFF input changes after the acknowledge SHALL NOT affect the running holdoff.
REQ-021 TRIG_ACK in IDLE or HOLDOFF SHALL be ignored.
REQ-022 TRIG_IN=1 while state is PENDING or HOLDOFF SHALL increment MISS_COUNT one cycle later, regardless of ENABLE.
  - This includes the cycle in which TRIG_ACK arrives, and the final HOLDOFF cycle.
REQ-023 Counters SHALL saturate at 0xFFFF and never wrap.
REQ-024 COUNT_CLEAR=1 SHALL zero both counters on the next edge.
  - It takes priority over a simultaneous increment.
  - It does not alter state or any other output.
REQ-025 TRIG_OUT SHALL never be high on two consecutive cycles.
REQ-026 Accepted triggers SHALL be separated by at least 2 cycles (accept, then acknowledge) plus HOLDOFF.

Reset
REQ-027 While RESET=1, outputs SHALL immediately take these values, independent of the clock:
  - state IDLE, holdoff counter 0;
  - TRIG_OUT=0, TRIG_PENDING=0, BUSY=0;
  - ACCEPT_COUNT=0, MISS_COUNT=0.
REQ-028 Reset asserted mid-PENDING or mid-HOLDOFF SHALL abandon the trigger.
  - The first cycle after release is IDLE and ready to accept.
REQ-029 A TRIG_IN coinciding with the first clock edge after reset release SHALL be accepted normally.

Verification
REQ-030 Basic accept: ENABLE=1, HOLDOFF=5, TRIG_IN at cycle 10, TRIG_ACK at cycle 14 ->
  - TRIG_OUT high only at cycle 11;
  - TRIG_PENDING high over cycles 11-14;
  - BUSY high over cycles 11-19;
  - TRIG_IN at cycle 20 accepted; ACCEPT_COUNT=2.
REQ-031 Misses: HOLDOFF=3, TRIG_IN at cycles 10, 12, 13 (ack at 13) and 16 ->
  - one accept, MISS_COUNT=2;
  - the cycle-16 trigger lands in HOLDOFF (14-16), so MISS_COUNT=3.
REQ-032 Zero holdoff: HOLDOFF=0, ack at cycle m -> BUSY low at m+1, and TRIG_IN at m+1 is accepted.
REQ-033 Saturation and clear:
  - force 70000 misses -> MISS_COUNT=0xFFFF;
  - COUNT_CLEAR together with TRIG_IN during HOLDOFF -> both counters 0 on the next cycle.
REQ-034 Disable and reset:
  - ENABLE=0 with TRIG_IN in IDLE -> no TRIG_OUT and counts unchanged;
  - RESET pulsed mid-HOLDOFF (HOLDOFF=100) -> BUSY=0 immediately and the next TRIG_IN after release is accepted.
